mxint_cat_sequencer: RTL and testbench

//   Block-level scheduler that merges two MXInt block streams into one for a
//   dim=-1 concatenation: per row it forwards IN0_BLOCKS blocks from input 0,

---
 rtl/mxint_cat_sequencer.sv | 133 +++++++++++++
 tb/tb_mxint_cat_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxint_cat_sequencer.sv
// Block scheduler for a dim=-1 MXInt concatenation. For each row it forwards
// IN0_BLOCKS blocks from input 0, then IN1_BLOCKS blocks from input 1, for ROWS rows per frame.
module mxint_cat_sequencer #(
  parameter int MAN_WIDTH  = 8,
  parameter int EXP_WIDTH  = 4,
  parameter int BLOCK_SIZE = 4,
  parameter int IN0_BLOCKS = 2,
  parameter int IN1_BLOCKS = 2,
  parameter int ROWS       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAN_WIDTH-1:0] mdata_in_0 [BLOCK_SIZE],
  input  logic [EXP_WIDTH-1:0] edata_in_0,
  input  logic                 data_in_0_valid,
  output logic                 data_in_0_ready,
  input  logic [MAN_WIDTH-1:0] mdata_in_1 [BLOCK_SIZE],
  input  logic [EXP_WIDTH-1:0] edata_in_1,
  input  logic                 data_in_1_valid,
  output logic                 data_in_1_ready,
  output logic [MAN_WIDTH-1:0] mdata_out_0 [BLOCK_SIZE],
  output logic [EXP_WIDTH-1:0] edata_out_0,
  output logic                 data_out_0_valid,
  input  logic                 data_out_0_ready,
  output logic                 data_out_0_src,
  output logic                 data_out_0_rlast,
  output logic                 data_out_0_flast
);

  localparam int MAX_BLOCKS = (IN0_BLOCKS > IN1_BLOCKS) ? IN0_BLOCKS : IN1_BLOCKS;
  localparam int CNT_W      = $clog2(MAX_BLOCKS + 1);
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0] IN0_LAST = CNT_W'(IN0_BLOCKS - 1);
  localparam logic [CNT_W-1:0] IN1_LAST = CNT_W'(IN1_BLOCKS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  generate
    if (IN0_BLOCKS < 1 || IN1_BLOCKS < 1 || ROWS < 1) begin : g_param_check
      $error("mxint_cat_sequencer: IN0_BLOCKS, IN1_BLOCKS and ROWS must all be >= 1");
    end
  endgenerate

  typedef enum logic {
    SEL0 = 1'b0,
    SEL1 = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     blk_cnt, blk_cnt_nxt;
  logic [ROW_W-1:0]     row_cnt, row_cnt_nxt;

  logic                 load;
  logic                 accept;
  logic                 seg_last;
  logic                 rlast_nxt;
  logic                 flast_nxt;
  logic [MAN_WIDTH-1:0] sel_mdata [BLOCK_SIZE];
  logic [EXP_WIDTH-1:0] sel_edata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SEL0;
      blk_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      blk_cnt <= blk_cnt_nxt;
      row_cnt <= row_cnt_nxt;
    end
  end

  // A row only advances when the input-1 segment closes.
  always_comb begin
    state_nxt   = state;
    blk_cnt_nxt = blk_cnt;
    row_cnt_nxt = row_cnt;
    if (accept) begin
      if (seg_last) begin
        blk_cnt_nxt = '0;
        if (state == SEL0) begin
          state_nxt = SEL1;
        end else begin
          state_nxt   = SEL0;
          row_cnt_nxt = (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
        end
      end else begin
        blk_cnt_nxt = blk_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    load            = !data_out_0_valid || data_out_0_ready;
    data_in_0_ready = (state == SEL0) && load;
    data_in_1_ready = (state == SEL1) && load;
    accept          = (state == SEL0) ? (data_in_0_valid && data_in_0_ready)
                                      : (data_in_1_valid && data_in_1_ready);
    seg_last        = (state == SEL0) ? (blk_cnt == IN0_LAST) : (blk_cnt == IN1_LAST);
    rlast_nxt       = (state == SEL1) && seg_last;
    flast_nxt       = rlast_nxt && (row_cnt == ROW_LAST);
    sel_edata       = (state == SEL0) ? edata_in_0 : edata_in_1;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sel_mdata[i] = (state == SEL0) ? mdata_in_0[i] : mdata_in_1[i];
    end
  end

  // Output register only reloads when free, so a stalled block holds stable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_0_valid <= 1'b0;
      edata_out_0      <= '0;
      data_out_0_src   <= 1'b0;
      data_out_0_rlast <= 1'b0;
      data_out_0_flast <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        mdata_out_0[i] <= '0;
      end
    end else if (accept) begin
      data_out_0_valid <= 1'b1;
      edata_out_0      <= sel_edata;
      data_out_0_src   <= (state == SEL1);
      data_out_0_rlast <= rlast_nxt;
      data_out_0_flast <= flast_nxt;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        mdata_out_0[i] <= sel_mdata[i];
      end
    end else if (data_out_0_ready) begin
      data_out_0_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mxint_cat_sequencer.sv
// Scoreboard bench for mxint_cat_sequencer: three parameter sets, random data and
// handshakes, expected order built from the concatenation rule itself.
module tb_mxint_cat_sequencer;

  localparam int MW      = 8;
  localparam int EW      = 4;
  localparam int BS      = 4;
  localparam int NCFG    = 3;
  localparam int DRAIN_T = 3000;
  localparam int GLOBAL_T = 20000;

  typedef logic [EW+MW*BS-1:0] blk_t;
  typedef struct {
    blk_t data;
    logic src;
    logic rlast;
    logic flast;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int N0  = (g == 1) ? 2 : (g == 2) ? 1 : 2;
    localparam int N1  = (g == 1) ? 3 : (g == 2) ? 1 : 2;
    localparam int NR  = (g == 0) ? 2 : 1;
    localparam int D0  = (g == 1) ? 5 : 0;
    localparam int NF  = (g == 0) ? 5 : 4;
    localparam int BPF = NR * (N0 + N1);

    logic          rst;
    logic [MW-1:0] mi0 [BS];
    logic [MW-1:0] mi1 [BS];
    logic [MW-1:0] mo  [BS];
    logic [EW-1:0] ei0, ei1, eo;
    logic          v0, v1, r0, r1, vo, ro, src, rlast, flast;

    blk_t q0 [$];
    blk_t q1 [$];
    exp_t expq [$];
    bit   sb_en = 1'b0;
    bit   sink_stop = 1'b0;
    bit   done = 1'b0;
    int   acc_cnt = 0;
    int   pops = 0;
    int   cyc = 0;
    int   first_acc_cyc = 0;
    int   last_pop_cyc = 0;

    mxint_cat_sequencer #(
      .MAN_WIDTH (MW),
      .EXP_WIDTH (EW),
      .BLOCK_SIZE(BS),
      .IN0_BLOCKS(N0),
      .IN1_BLOCKS(N1),
      .ROWS      (NR)
    ) dut (
      .clk             (clk),
      .rst             (rst),
      .mdata_in_0      (mi0),
      .edata_in_0      (ei0),
      .data_in_0_valid (v0),
      .data_in_0_ready (r0),
      .mdata_in_1      (mi1),
      .edata_in_1      (ei1),
      .data_in_1_valid (v1),
      .data_in_1_ready (r1),
      .mdata_out_0     (mo),
      .edata_out_0     (eo),
      .data_out_0_valid(vo),
      .data_out_0_ready(ro),
      .data_out_0_src  (src),
      .data_out_0_rlast(rlast),
      .data_out_0_flast(flast)
    );

    function automatic blk_t pack_out();
      blk_t b;
      b[MW*BS +: EW] = eo;
      for (int k = 0; k < BS; k++) b[k*MW +: MW] = mo[k];
      return b;
    endfunction

    // First two blocks of each stream carry the extreme exponent/mantissa codes.
    function automatic blk_t make_blk(input int idx, input int port);
      blk_t b;
      b[MW*BS +: EW] = EW'($urandom);
      for (int k = 0; k < BS; k++) b[k*MW +: MW] = MW'($urandom);
      if (idx < 2) begin
        b[MW*BS +: EW] = ((idx == 0) == (port == 0)) ? {EW{1'b1}} : {EW{1'b0}};
        for (int k = 0; k < BS; k++)
          b[k*MW +: MW] = ((idx == 0) == (port == 0)) ? 8'h80 : 8'h7F;
      end
      return b;
    endfunction

    function automatic int frame_mode(input int f);
      if (f == 0) return 0;
      if (g == 0 && f < 3) return 1;
      return 2;
    endfunction

    task automatic set_input(input int port, input blk_t b);
      if (port == 0) begin
        ei0 = b[MW*BS +: EW];
        for (int k = 0; k < BS; k++) mi0[k] = b[k*MW +: MW];
      end else begin
        ei1 = b[MW*BS +: EW];
        for (int k = 0; k < BS; k++) mi1[k] = b[k*MW +: MW];
      end
    endtask

    task automatic applyStimulus(input int port);
      int i = 0;
      int n = (port == 0) ? q0.size() : q1.size();
      int per_frame = (port == 0) ? NR * N0 : NR * N1;
      if (port == 0) begin
        repeat (D0) begin
          @(posedge clk);
          #1;
        end
      end
      while (i < n) begin
        bit vv;
        bit hs;
        vv = (frame_mode(i / per_frame) == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        set_input(port, (port == 0) ? q0[i] : q1[i]);
        if (port == 0) v0 = vv; else v1 = vv;
        @(negedge clk);
        hs = (port == 0) ? (v0 && r0) : (v1 && r1);
        @(posedge clk);
        #1;
        if (hs) i++;
      end
      if (port == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drive_sink();
      bit tog = 1'b1;
      while (!sink_stop) begin
        int m;
        m = frame_mode(pops / BPF);
        ro = (m == 0) ? 1'b1 : (m == 1) ? tog : ($urandom_range(0, 3) != 0);
        tog = !tog;
        @(posedge clk);
        #1;
      end
      ro = 1'b1;
    endtask

    task automatic do_reset();
      v0 = 1'b0;
      v1 = 1'b0;
      ro = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("cfg%0d_reset_valid", g), 64'(vo), 64'(0));
      checkOutput($sformatf("cfg%0d_reset_data", g), 64'(pack_out()), 64'(0));
      checkOutput($sformatf("cfg%0d_reset_sideband", g), 64'({src, rlast, flast}), 64'(0));
      checkOutput($sformatf("cfg%0d_reset_ready0", g), 64'(r0), 64'(1));
      checkOutput($sformatf("cfg%0d_reset_ready1", g), 64'(r1), 64'(0));
      rst = 1'b1;
    endtask

    // Reset one cycle after the third accepted block; the stream must restart at input 0.
    task automatic reset_test();
      blk_t a = {4'h5, 8'h11, 8'h22, 8'h33, 8'h44};
      blk_t b = {4'hA, 8'hC1, 8'hD2, 8'hE3, 8'hF4};
      int   hs_n = 0;
      int   t = 0;
      set_input(0, a);
      set_input(1, b);
      v0 = 1'b1;
      v1 = 1'b1;
      ro = 1'b1;
      while (hs_n < 3 && t < 20) begin
        @(negedge clk);
        if ((v0 && r0) || (v1 && r1)) hs_n++;
        @(posedge clk);
        #1;
        t++;
      end
      checkOutput($sformatf("cfg%0d_rst_three_accepts", g), 64'(hs_n), 64'(3));
      checkOutput($sformatf("cfg%0d_pre_rst_src", g), 64'(src), 64'((2 % (N0 + N1)) >= N0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("cfg%0d_midrst_valid", g), 64'(vo), 64'(0));
      checkOutput($sformatf("cfg%0d_midrst_ready0", g), 64'(r0), 64'(1));
      checkOutput($sformatf("cfg%0d_midrst_ready1", g), 64'(r1), 64'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("cfg%0d_postrst_valid", g), 64'(vo), 64'(1));
      checkOutput($sformatf("cfg%0d_postrst_src", g), 64'(src), 64'(0));
      checkOutput($sformatf("cfg%0d_postrst_data", g), 64'(pack_out()), 64'(a));
      checkOutput($sformatf("cfg%0d_postrst_rlast", g), 64'(rlast), 64'(0));
      v0 = 1'b0;
      v1 = 1'b0;
    endtask

    // Monitor: ready rule, stall stability and in-order scoreboard comparison.
    logic held_v = 1'b0;
    blk_t held_d;
    logic [2:0] held_sb;
    initial begin
      forever begin
        logic load_e;
        int   nsrc;
        exp_t e;
        @(negedge clk);
        cyc++;
        if (sb_en) begin
          load_e = !vo || ro;
          nsrc = ((acc_cnt % (N0 + N1)) < N0) ? 0 : 1;
          checkOutput($sformatf("cfg%0d_in0_ready", g), 64'(r0), 64'((nsrc == 0) && load_e));
          checkOutput($sformatf("cfg%0d_in1_ready", g), 64'(r1), 64'((nsrc == 1) && load_e));
          if (held_v) begin
            checkOutput($sformatf("cfg%0d_hold_valid", g), 64'(vo), 64'(1));
            checkOutput($sformatf("cfg%0d_hold_data", g), 64'(pack_out()), 64'(held_d));
            checkOutput($sformatf("cfg%0d_hold_sideband", g), 64'({src, rlast, flast}), 64'(held_sb));
          end
          if ((v0 && r0) || (v1 && r1)) begin
            if (acc_cnt == 0) first_acc_cyc = cyc;
            acc_cnt++;
          end
          if (vo && ro) begin
            if (expq.size() == 0) begin
              checkOutput($sformatf("cfg%0d_unexpected_output", g), 64'(1), 64'(0));
            end else begin
              e = expq.pop_front();
              checkOutput($sformatf("cfg%0d_blk%0d_data", g, pops), 64'(pack_out()), 64'(e.data));
              checkOutput($sformatf("cfg%0d_blk%0d_src", g, pops), 64'(src), 64'(e.src));
              checkOutput($sformatf("cfg%0d_blk%0d_rlast", g, pops), 64'(rlast), 64'(e.rlast));
              checkOutput($sformatf("cfg%0d_blk%0d_flast", g, pops), 64'(flast), 64'(e.flast));
              if (pops == 0)
                checkOutput($sformatf("cfg%0d_first_latency", g), 64'(cyc - first_acc_cyc), 64'(1));
              else if (pops < BPF)
                checkOutput($sformatf("cfg%0d_throughput", g), 64'(cyc - last_pop_cyc), 64'(1));
              last_pop_cyc = cyc;
              pops++;
            end
          end
          held_v  = vo && !ro;
          held_d  = pack_out();
          held_sb = {src, rlast, flast};
        end
      end
    end

    initial begin
      int i0 = 0;
      int i1 = 0;
      int total;
      int t = 0;
      rst = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      ro = 1'b1;
      set_input(0, '0);
      set_input(1, '0);
      for (int i = 0; i < NF * NR * N0; i++) q0.push_back(make_blk(i, 0));
      for (int i = 0; i < NF * NR * N1; i++) q1.push_back(make_blk(i, 1));
      for (int f = 0; f < NF; f++) begin
        for (int r = 0; r < NR; r++) begin
          for (int k = 0; k < N0; k++) begin
            expq.push_back('{q0[i0], 1'b0, 1'b0, 1'b0});
            i0++;
          end
          for (int k = 0; k < N1; k++) begin
            expq.push_back('{q1[i1], 1'b1, (k == N1 - 1), (k == N1 - 1) && (r == NR - 1)});
            i1++;
          end
        end
      end
      total = expq.size();
      @(posedge clk);
      #1;
      do_reset();
      reset_test();
      do_reset();
      sb_en = 1'b1;
      fork
        applyStimulus(0);
        applyStimulus(1);
        drive_sink();
      join_none
      while (pops < total && t < DRAIN_T) begin
        @(posedge clk);
        t++;
      end
      checkOutput($sformatf("cfg%0d_drain_complete", g), 64'(pops), 64'(total));
      sink_stop = 1'b1;
      done = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && t < GLOBAL_T) begin
      @(posedge clk);
      t++;
    end
    checkOutput("global_completion", 64'(t < GLOBAL_T), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
